oam_dma_ctrl: RTL

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies DMA_LEN bytes from a CPU-selected source page into OAM.
// It shares the single memory port with the CPU, which is stalled while the copy runs.
module oam_dma_ctrl #(
    parameter int          DMA_LEN  = 160,
    parameter logic [15:0] DST_BASE = 16'hFE00,
    parameter logic [15:0] REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_gnt,
    output logic        mem_wen,
    output logic [15:0] mem_r_addr,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    input  logic [7:0]  mem_r_data,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state_q;
    logic [7:0] page_q;
    logic [7:0] idx_q;
    logic [7:0] src_page;
    logic       reg_wr;

    // Pages E0..FF are the echo mirror of C0..DF.
    assign src_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
    assign reg_wr   = cpu_req & cpu_we & cpu_gnt & (cpu_addr == REG_ADDR);
    assign dma_busy = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the block order cannot change behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= 8'hFF;
            idx_q    <= 8'h00;
            dma_done <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state_q)
                IDLE, START: begin
                    if (reg_wr) begin
                        page_q  <= cpu_wdata;
                        idx_q   <= 8'h00;
                        state_q <= START;
                    end else if (state_q == START) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= 8'h00;
                        state_q  <= IDLE;
                        dma_done <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 8'h01;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before any branch, which keeps this
    // block purely combinational and rules out inferred latches.
    always_comb begin
        cpu_gnt    = 1'b1;
        mem_r_addr = cpu_addr;
        mem_w_addr = cpu_addr;
        mem_w_data = cpu_wdata;
        mem_wen    = cpu_req & cpu_we & (cpu_addr != REG_ADDR);
        cpu_rdata  = (cpu_addr == REG_ADDR) ? page_q : mem_r_data;
        if (state_q == XFER) begin
            cpu_gnt    = 1'b0;
            mem_r_addr = {src_page, idx_q};
            mem_w_addr = DST_BASE + {8'h00, idx_q};
            mem_w_data = mem_r_data;
            mem_wen    = 1'b1;
            cpu_rdata  = 8'hFF;
        end
    end

endmodule
